// File: rtl/dm_pkg.sv
// Shared constants for the data-memory responder: MMIO window base, register
// offsets and STATUS word layout.
package dm_pkg;

    localparam logic [23:0] MMIO_BASE  = 24'hFFFFFF;

    localparam logic [7:0]  OFF_TXDATA = 8'h00;
    localparam logic [7:0]  OFF_STATUS = 8'h04;
    localparam logic [7:0]  OFF_CYCLE  = 8'h08;

    localparam int STAT_OVF_BIT   = 31;
    localparam int STAT_FULL_BIT  = 30;
    localparam int STAT_EMPTY_BIT = 29;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_TXDATA,
        SEL_STATUS,
        SEL_CYCLE,
        SEL_NONE
    } dm_sel_e;

    function automatic logic [31:0] status_word(input logic       ovf,
                                                input logic       full,
                                                input logic       empty,
                                                input logic [7:0] cnt);
        logic [31:0] w;
        w                 = '0;
        w[STAT_OVF_BIT]   = ovf;
        w[STAT_FULL_BIT]  = full;
        w[STAT_EMPTY_BIT] = empty;
        w[7:0]            = cnt;
        return w;
    endfunction

endpackage

// File: rtl/dm_fifo.sv
// Synchronous FIFO with a first-word head output; a push into a full FIFO
// is accepted only when a pop frees a slot on the same edge.
module dm_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dm_responder.sv
// DM-bus responder for the single-cycle CPU: word RAM plus an MMIO window
// holding an output FIFO (TXDATA/STATUS) and a free-running cycle counter.
module dm_responder
    import dm_pkg::*;
#(
    parameter int RAM_AW     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] DM_addr,
    input  logic [31:0] DM_wdata,
    input  logic        DM_CS,
    input  logic        DM_R,
    input  logic        DM_W,
    output logic [31:0] rdata,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       ram [2**RAM_AW];
    logic [RAM_AW-1:0] ram_idx;
    dm_sel_e           sel;
    logic              rd_en;
    logic              wr_en;
    logic              tx_push;
    logic              pop_fire;
    logic              drop;
    logic              status_rd;
    logic              overflow;
    logic [31:0]       cycle_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;

    always_comb begin
        sel = SEL_RAM;
        if (DM_addr[31:8] == MMIO_BASE) begin
            case (DM_addr[7:0])
                OFF_TXDATA: sel = SEL_TXDATA;
                OFF_STATUS: sel = SEL_STATUS;
                OFF_CYCLE:  sel = SEL_CYCLE;
                default:    sel = SEL_NONE;
            endcase
        end
    end

    assign ram_idx   = DM_addr[RAM_AW+1:2];
    assign rd_en     = DM_CS && DM_R;
    assign wr_en     = DM_CS && DM_W;
    assign tx_push   = wr_en && (sel == SEL_TXDATA);
    assign status_rd = rd_en && (sel == SEL_STATUS);
    assign pop_fire  = out_valid && out_ready;
    assign drop      = tx_push && fifo_full && !pop_fire;

    always_ff @(posedge clk) begin
        if (wr_en && (sel == SEL_RAM)) begin
            ram[ram_idx] <= DM_wdata;
        end
    end

    // A drop on the same edge as the clearing STATUS read keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (status_rd) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= '0;
        end else if (wr_en && (sel == SEL_CYCLE)) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    dm_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .pop   (pop_fire),
        .wdata (DM_wdata),
        .head  (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_valid = !fifo_empty;

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            case (sel)
                SEL_RAM:    rdata = ram[ram_idx];
                SEL_STATUS: rdata = status_word(overflow, fifo_full, fifo_empty, 8'(fifo_count));
                SEL_CYCLE:  rdata = cycle_cnt;
                default:    rdata = '0;
            endcase
        end
    end

endmodule
